zet_wb_master_p: RTL and testbench

ZET_WB_MASTER_P -- requirements
Module: zet_wb_master_p

---
 rtl/zet_wb_master_p.sv | 147 ++++++++++++++
 tb/tb_zet_wb_master_p.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/zet_wb_master_p.sv
// Zet CPU to 16-bit Wishbone master: byte/word memory and I/O requests, with odd-addressed
// words split into two bus phases, per-phase timeout and error reporting back to the CPU.
//
// state | meaning
// IDLE  | waiting for a CPU request; cpu_block follows op
// ACC1  | first (or only) bus phase
// ACC2  | second phase of an odd word access (upper byte at next word)
// DONE  | one-cycle completion; CPU samples cpu_dat_i / cpu_err
module zet_wb_master_p #(
  parameter int ADR_W   = 20,
  parameter int SEXT    = 1,
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cpu_memop,
  input  logic             cpu_m_io,
  input  logic             cpu_byte_o,
  input  logic [ADR_W-1:0] cpu_adr_o,
  input  logic [15:0]      cpu_dat_o,
  input  logic             cpu_we_o,
  output logic             cpu_block,
  output logic [15:0]      cpu_dat_i,
  output logic             cpu_err,
  input  logic [15:0]      wb_dat_i,
  output logic [15:0]      wb_dat_o,
  output logic [ADR_W-2:0] wb_adr_o,
  output logic             wb_we_o,
  output logic             wb_tga_o,
  output logic [1:0]       wb_sel_o,
  output logic             wb_stb_o,
  output logic             wb_cyc_o,
  input  logic             wb_ack_i,
  input  logic             wb_err_i
);

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t           state;
  logic [ADR_W-1:0] adr_r;
  logic             byte_r;
  logic             we_r;
  logic             mio_r;
  logic [15:0]      dat_r;
  logic [TO_W-1:0]  cnt;

  logic             op;
  logic             a0;
  logic             two_phase;
  logic             in_acc;
  logic             timed_out;
  logic             fail;
  logic [ADR_W-2:0] wadr;

  function automatic logic [15:0] ext8(input logic [7:0] b);
    return {{8{(SEXT != 0) & b[7]}}, b};
  endfunction

  assign op        = cpu_memop | cpu_m_io;
  assign a0        = adr_r[0];
  assign two_phase = a0 & ~byte_r;
  assign in_acc    = (state == ACC1) || (state == ACC2);
  assign wadr      = adr_r[ADR_W-1:1];
  // The cycle that would be the TIMEOUT-th wait cycle ends the phase instead.
  assign timed_out = (TIMEOUT != 0) && (cnt == TO_LAST) && !wb_ack_i;
  assign fail      = wb_err_i | timed_out;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      adr_r     <= '0;
      byte_r    <= 1'b0;
      we_r      <= 1'b0;
      mio_r     <= 1'b0;
      dat_r     <= '0;
      cnt       <= '0;
      cpu_dat_i <= '0;
      cpu_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (op) begin
            adr_r   <= cpu_adr_o;
            byte_r  <= cpu_byte_o;
            we_r    <= cpu_we_o;
            mio_r   <= cpu_m_io;
            dat_r   <= cpu_dat_o;
            cpu_err <= 1'b0;
            cnt     <= '0;
            state   <= ACC1;
          end
        end
        ACC1: begin
          if (fail) begin
            cpu_err <= 1'b1;
            state   <= DONE;
          end else if (wb_ack_i) begin
            if (!we_r) begin
              if (a0)          cpu_dat_i <= ext8(wb_dat_i[15:8]);
              else if (byte_r) cpu_dat_i <= ext8(wb_dat_i[7:0]);
              else             cpu_dat_i <= wb_dat_i;
            end
            cnt   <= '0;
            state <= two_phase ? ACC2 : DONE;
          end else begin
            cnt <= cnt + TO_W'(1);
          end
        end
        ACC2: begin
          if (fail) begin
            cpu_err <= 1'b1;
            state   <= DONE;
          end else if (wb_ack_i) begin
            if (!we_r) cpu_dat_i[15:8] <= wb_dat_i[7:0];
            state <= DONE;
          end else begin
            cnt <= cnt + TO_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    cpu_block = 1'b1;
    if (state == IDLE)      cpu_block = op;
    else if (state == DONE) cpu_block = 1'b0;
  end

  always_comb begin
    wb_sel_o = 2'b00;
    if (state == ACC1)      wb_sel_o = a0 ? 2'b10 : (byte_r ? 2'b01 : 2'b11);
    else if (state == ACC2) wb_sel_o = 2'b01;
  end

  assign wb_cyc_o = in_acc;
  assign wb_stb_o = in_acc;
  assign wb_adr_o = (state == ACC2) ? wadr + (ADR_W-1)'(1) : wadr;
  assign wb_dat_o = a0 ? {dat_r[7:0], dat_r[15:8]} : dat_r;
  assign wb_we_o  = we_r & in_acc;
  assign wb_tga_o = mio_r;

endmodule

// File: tb/tb_zet_wb_master_p.sv
// Bench for zet_wb_master_p: directed cases plus random transfers against a byte-addressed
// reference memory; a second instance (SEXT=0, no timeout) shares the bus stimulus.
module tb_zet_wb_master_p;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_memop, cpu_m_io, cpu_byte_o, cpu_we_o;
  logic [19:0] cpu_adr_o;
  logic [15:0] cpu_dat_o;
  logic [15:0] wb_dat_i;
  logic        wb_ack_i, wb_err_i;

  logic        cpu_block, cpu_err, wb_we_o, wb_tga_o, wb_stb_o, wb_cyc_o;
  logic [15:0] cpu_dat_i, wb_dat_o;
  logic [18:0] wb_adr_o;
  logic [1:0]  wb_sel_o;

  logic        z_block, z_err, z_we, z_tga, z_stb, z_cyc;
  logic [15:0] z_dat_i, z_dat_o;
  logic [18:0] z_adr;
  logic [1:0]  z_sel;

  always #5 clk = ~clk;

  zet_wb_master_p #(.ADR_W(20), .SEXT(1), .TO_W(8), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .cpu_memop(cpu_memop), .cpu_m_io(cpu_m_io),
    .cpu_byte_o(cpu_byte_o), .cpu_adr_o(cpu_adr_o), .cpu_dat_o(cpu_dat_o), .cpu_we_o(cpu_we_o),
    .cpu_block(cpu_block), .cpu_dat_i(cpu_dat_i), .cpu_err(cpu_err), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_adr_o(wb_adr_o), .wb_we_o(wb_we_o), .wb_tga_o(wb_tga_o),
    .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i),
    .wb_err_i(wb_err_i));

  zet_wb_master_p #(.ADR_W(20), .SEXT(0), .TO_W(8), .TIMEOUT(0)) dut_z (
    .wb_clk_i(clk), .wb_rst_i(rst), .cpu_memop(cpu_memop), .cpu_m_io(cpu_m_io),
    .cpu_byte_o(cpu_byte_o), .cpu_adr_o(cpu_adr_o), .cpu_dat_o(cpu_dat_o), .cpu_we_o(cpu_we_o),
    .cpu_block(z_block), .cpu_dat_i(z_dat_i), .cpu_err(z_err), .wb_dat_i(wb_dat_i),
    .wb_dat_o(z_dat_o), .wb_adr_o(z_adr), .wb_we_o(z_we), .wb_tga_o(z_tga),
    .wb_sel_o(z_sel), .wb_stb_o(z_stb), .wb_cyc_o(z_cyc), .wb_ack_i(wb_ack_i),
    .wb_err_i(wb_err_i));

  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_dat, exp_datz;
  logic        exp_err;
  bit          z_valid;

  logic [15:0] smem [int];   // slave word memory, driven by bus activity
  logic [7:0]  rmem [int];   // reference byte memory, updated from CPU-level semantics

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ext(input logic [7:0] b, input bit s);
    return {{8{s & b[7]}}, b};
  endfunction

  function automatic logic [7:0] rb(input int a);
    return rmem.exists(a) ? rmem[a] : 8'h00;
  endfunction

  function automatic logic [15:0] sw(input int a);
    return smem.exists(a) ? smem[a] : 16'h0000;
  endfunction

  task automatic put_word(input int wa, input logic [15:0] v);
    smem[wa] = v;
    rmem[2*wa] = v[7:0];
    rmem[2*wa+1] = v[15:8];
  endtask

  // Entered and left at posedge+1 with the DUT idle.
  task automatic xfer(input logic [19:0] adr, input logic byt, input logic we, input logic mio,
                      input logic [15:0] wd, input int w1, input int w2, input int errph,
                      input bit ewa);
    logic        a0, two;
    logic [1:0]  sel;
    logic [18:0] wa;
    logic [15:0] wdo, cur;
    logic [7:0]  b0, b1;
    int          adr1, waits, nph;
    bit          last, to, ok1, ok2, stop;
    a0   = adr[0];
    two  = a0 && !byt;
    nph  = two ? 2 : 1;
    wdo  = a0 ? {wd[7:0], wd[15:8]} : wd;
    adr1 = int'((adr + 20'd1) & 20'hFFFFF);
    b0   = rb(int'(adr));
    b1   = rb(adr1);
    ok1 = 0; ok2 = 0; stop = 0;

    cpu_memop = !mio; cpu_m_io = mio; cpu_adr_o = adr; cpu_byte_o = byt;
    cpu_we_o = we; cpu_dat_o = wd;
    #1;
    chk("idle_block", cpu_block, 1);
    chk("idle_cyc", wb_cyc_o, 0);
    @(posedge clk); #1;
    cpu_memop = 0; cpu_m_io = 0; cpu_adr_o = 20'($urandom); cpu_dat_o = 16'($urandom);
    cpu_we_o = 1'($urandom); cpu_byte_o = 1'($urandom);
    chk("err_clear", cpu_err, 0);

    for (int p = 1; p <= nph && !stop; p++) begin
      sel   = (p == 2) ? 2'b01 : (a0 ? 2'b10 : (byt ? 2'b01 : 2'b11));
      wa    = adr[19:1] + ((p == 2) ? 19'd1 : 19'd0);
      waits = (p == 1) ? w1 : w2;
      to    = 0;
      for (int c = 0; c < 64; c++) begin
        chk("cyc", wb_cyc_o, 1);
        chk("stb", wb_stb_o, 1);
        chk("block", cpu_block, 1);
        chk("sel", wb_sel_o, sel);
        chk("adr", wb_adr_o, wa);
        chk("we", wb_we_o, we);
        chk("tga", wb_tga_o, mio);
        chk("dat_o", wb_dat_o, wdo);
        last = (c == waits);
        to   = !last && (c == TO - 1);
        if (last) begin
          wb_err_i = (errph == p);
          wb_ack_i = (errph != p) || ewa;
          wb_dat_i = sw(int'(wa));
          if (we && errph != p) begin
            cur = sw(int'(wa));
            if (wb_sel_o[0]) cur[7:0]  = wb_dat_o[7:0];
            if (wb_sel_o[1]) cur[15:8] = wb_dat_o[15:8];
            smem[int'(wa)] = cur;
          end
        end
        @(posedge clk); #1;
        wb_ack_i = 0; wb_err_i = 0; wb_dat_i = 16'($urandom);
        if (last || to) break;
      end
      if (to || errph == p) begin
        stop = 1;
        if (to) z_valid = 0;
      end else if (p == 1) ok1 = 1;
      else ok2 = 1;
    end

    exp_err = !(ok1 && (!two || ok2));
    if (!we) begin
      if (byt || !a0) begin
        if (ok1) begin
          exp_dat  = byt ? ext(b0, 1) : {b1, b0};
          exp_datz = byt ? ext(b0, 0) : {b1, b0};
        end
      end else if (ok1) begin
        exp_dat  = ok2 ? {b1, b0} : ext(b0, 1);
        exp_datz = ok2 ? {b1, b0} : ext(b0, 0);
      end
    end else begin
      if (ok1) rmem[int'(adr)] = wd[7:0];
      if (!byt && ((!a0 && ok1) || (a0 && ok2))) rmem[adr1] = wd[15:8];
    end

    chk("done_cyc", wb_cyc_o, 0);
    chk("done_block", cpu_block, 0);
    chk("done_dat", cpu_dat_i, exp_dat);
    chk("done_err", cpu_err, exp_err);
    if (z_valid) begin
      chk("z_dat", z_dat_i, exp_datz);
      chk("z_err", z_err, exp_err);
    end
    @(posedge clk); #1;
    chk("back_idle_cyc", wb_cyc_o, 0);
    chk("back_idle_block", cpu_block, 0);
  endtask

  initial begin
    logic [19:0] ra;
    rst = 1; cpu_memop = 0; cpu_m_io = 0; cpu_byte_o = 0; cpu_we_o = 0;
    cpu_adr_o = 0; cpu_dat_o = 0; wb_dat_i = 0; wb_ack_i = 0; wb_err_i = 0;
    exp_dat = 0; exp_datz = 0; exp_err = 0; z_valid = 1;
    #12;
    chk("rst_cyc", wb_cyc_o, 0);
    chk("rst_sel", wb_sel_o, 0);
    chk("rst_dat", cpu_dat_i, 0);
    chk("rst_err", cpu_err, 0);
    chk("rst_block0", cpu_block, 0);
    cpu_memop = 1; #1;
    chk("rst_block1", cpu_block, 1);
    chk("rst_stb", wb_stb_o, 0);
    cpu_memop = 0;
    @(posedge clk); #1; rst = 0;
    @(posedge clk); #1;

    // aligned word read, two wait states
    put_word(20'h0091A, 16'hBEEF);
    xfer(20'h01234, 0, 0, 0, 16'h0, 2, 0, 0, 0);
    chk("aligned_word", cpu_dat_i, 16'hBEEF);

    // odd word read
    put_word(20'h00080, 16'h7F00);
    put_word(20'h00081, 16'h0080);
    xfer(20'h00101, 0, 0, 0, 16'h0, 1, 2, 0, 0);
    chk("odd_word", cpu_dat_i, 16'h807F);

    // odd byte read, sign vs zero extension
    put_word(20'h00100, 16'h8000);
    xfer(20'h00201, 1, 0, 1, 16'h0, 0, 0, 0, 0);
    chk("odd_byte_sext", cpu_dat_i, 16'hFF80);
    chk("odd_byte_zext", z_dat_i, 16'h0080);

    // odd word write at top of space wraps to word 0
    xfer(20'hFFFFF, 0, 1, 0, 16'hA55A, 1, 0, 0, 0);
    xfer(20'hFFFFF, 0, 0, 0, 16'h0, 0, 0, 0, 0);
    chk("wrap_readback", cpu_dat_i, 16'hA55A);

    // ack and err together in ACC1
    xfer(20'h00101, 0, 0, 0, 16'h0, 0, 0, 1, 1);
    chk("ack_err_err", cpu_err, 1);
    chk("ack_err_dat", cpu_dat_i, 16'hA55A);

    // timeout, then next request clears cpu_err
    xfer(20'h00010, 0, 0, 0, 16'h0, 10, 0, 0, 0);
    chk("timeout_err", cpu_err, 1);
    xfer(20'h00101, 0, 0, 0, 16'h0, 0, 0, 0, 0);
    chk("err_cleared", cpu_err, 0);

    // reset during ACC2
    cpu_memop = 1; cpu_adr_o = 20'h00101; cpu_byte_o = 0; cpu_we_o = 0;
    @(posedge clk); #1;
    cpu_memop = 0;
    chk("pre_rst_acc1", wb_cyc_o, 1);
    wb_ack_i = 1; wb_dat_i = 16'h1200;
    @(posedge clk); #1;
    wb_ack_i = 0;
    chk("pre_rst_acc2_sel", wb_sel_o, 2'b01);
    cpu_memop = 1; rst = 1; #1;
    chk("rst_acc2_cyc", wb_cyc_o, 0);
    chk("rst_acc2_stb", wb_stb_o, 0);
    chk("rst_acc2_we", wb_we_o, 0);
    chk("rst_acc2_sel", wb_sel_o, 0);
    chk("rst_acc2_block", cpu_block, 1);
    chk("rst_acc2_dat", cpu_dat_i, 0);
    cpu_memop = 0;
    @(posedge clk); #1; rst = 0;
    exp_dat = 0; exp_datz = 0; exp_err = 0; z_valid = 1;
    @(posedge clk); #1;
    chk("post_rst_cyc", wb_cyc_o, 0);

    // random transfers against the reference memory
    for (int i = 0; i < 60; i++) begin
      ra = ($urandom_range(0, 7) == 0) ? (20'hFFFFE | 20'($urandom_range(0, 1)))
                                        : 20'($urandom_range(0, 255));
      xfer(ra, 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom),
           $urandom_range(0, 3), $urandom_range(0, 3),
           ($urandom_range(0, 7) == 0) ? $urandom_range(1, 2) : 0, 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule
